// File: rtl/sync_updown_counter.sv
// -----------------------------------------------------------------------------
// sync_updown_counter
//
// Parametrised synchronous binary counter with count enable, up/down control,
// parallel load, programmable modulus and optional saturation. All bits update
// on the same rising clock edge.
//
// Parameters
//   WIDTH     counter width in bits (>= 1)
//   MODULO    count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//   SATURATE  0: wrap at the range ends, 1: hold at the range ends
//
// Ports
//   clk_i       in   1      clock, rising edge
//   rst_ni      in   1      synchronous active-low reset
//   en_i        in   1      count enable
//   up_i        in   1      direction, 1 = increment, 0 = decrement
//   load_i      in   1      parallel load strobe (overrides en_i / up_i)
//   load_val_i  in   WIDTH  load value, clamped to MODULO-1
//   count_o     out  WIDTH  registered count
//   tc_o        out  1      terminal count (combinational), for cascading
//   wrap_o      out  1      registered one-cycle pulse after a wrap
// -----------------------------------------------------------------------------
module sync_updown_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULO   = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o
);

    // Reject parameter combinations that cannot be represented.
    generate
        if (WIDTH < 1 || MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_param_check
            $error("sync_updown_counter: illegal WIDTH/MODULO combination");
        end
    endgenerate

    // Top of the count range; fits in WIDTH bits even when MODULO == 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    // Modulus extended by one bit so the load clamp compare never overflows.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;

    logic             at_max;
    logic             at_min;
    logic             at_end;
    logic             load_clamp;

    assign at_max     = (count_reg == MAX_VAL);
    assign at_min     = (count_reg == '0);
    // Boundary in the currently selected direction.
    assign at_end     = up_i ? at_max : at_min;
    assign load_clamp = ({1'b0, load_val_i} >= MOD_EXT);

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (load_i) begin
            count_next = load_clamp ? MAX_VAL : load_val_i;
        end else if (en_i) begin
            if (at_end) begin
                // Saturating mode simply holds at the boundary.
                if (!SATURATE) begin
                    count_next = up_i ? '0 : MAX_VAL;
                    wrap_next  = 1'b1;
                end
            end else begin
                count_next = up_i ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1);
            end
        end
    end

    // Reset is only seen on clock edges and beats load and count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count_o = count_reg;
    assign wrap_o  = wrap_reg;
    // Boundary flag only; asserted in saturating mode too.
    assign tc_o    = en_i & ~load_i & at_end;

endmodule

// File: tb/tb_sync_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_sync_updown_counter
//
// Three stand-alone counters (MODULO 8 wrap, MODULO 6 wrap, MODULO 6 saturate)
// share one stimulus stream; a fourth pair of default counters is cascaded via
// tc_o -> en_i. Expected values come from an arithmetic reference model and are
// queued per cycle; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_sync_updown_counter;

    logic clk;
    logic rst_n;
    logic en;
    logic up;
    logic ld;
    logic [2:0] ld_val;
    logic casc_en;

    logic [2:0] dut_cnt  [3];
    logic       dut_tc   [3];
    logic       dut_wrap [3];

    logic [2:0] lo_cnt, hi_cnt;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

    int tests  = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            sync_updown_counter #(
                .WIDTH   (3),
                .MODULO  ((gi == 0) ? 8 : 6),
                .SATURATE((gi == 2) ? 1'b1 : 1'b0)
            ) u_dut (
                .clk_i     (clk),
                .rst_ni    (rst_n),
                .en_i      (en),
                .up_i      (up),
                .load_i    (ld),
                .load_val_i(ld_val),
                .count_o   (dut_cnt[gi]),
                .tc_o      (dut_tc[gi]),
                .wrap_o    (dut_wrap[gi])
            );
        end
    endgenerate

    sync_updown_counter u_lo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (casc_en),
        .up_i      (1'b1),
        .load_i    (1'b0),
        .load_val_i(3'd0),
        .count_o   (lo_cnt),
        .tc_o      (lo_tc),
        .wrap_o    (lo_wrap)
    );

    sync_updown_counter u_hi (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (lo_tc),
        .up_i      (1'b1),
        .load_i    (1'b0),
        .load_val_i(3'd0),
        .count_o   (hi_cnt),
        .tc_o      (hi_tc),
        .wrap_o    (hi_wrap)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0][2:0] cnt;
        logic [2:0]      wrap;
        logic [2:0]      tc;
        logic [5:0]      casc;
    } exp_t;

    exp_t q[$];

    int m_cnt  [3];
    bit m_wrap [3];
    int m_casc;

    function automatic int mod_of(input int i);
        return (i == 0) ? 8 : 6;
    endfunction

    function automatic bit sat_of(input int i);
        return (i == 2);
    endfunction

    // Next state from modular arithmetic (wrap) or min/max (saturate).
    function automatic void model_step(input int m, input bit sat, input bit r_n,
                                       input bit e, input bit u, input bit l,
                                       input int lv, input int c,
                                       output int nc, output bit nw);
        nc = c;
        nw = 1'b0;
        if (!r_n) begin
            nc = 0;
        end else if (l) begin
            nc = (lv >= m) ? m - 1 : lv;
        end else if (e) begin
            if (sat) begin
                nc = u ? ((c + 1 > m - 1) ? m - 1 : c + 1)
                       : ((c - 1 < 0) ? 0 : c - 1);
            end else begin
                nc = (c + (u ? 1 : m - 1)) % m;
                nw = u ? (c == m - 1) : (c == 0);
            end
        end
    endfunction

    // Apply inputs for one cycle: queue what the DUT must show now, then
    // advance the model across the coming edge.
    task automatic drive(input bit r_n, input bit e, input bit u, input bit l,
                         input int lv, input bit ce);
        exp_t x;
        int   nc;
        bit   nw;
        rst_n   = r_n;
        en      = e;
        up      = u;
        ld      = l;
        ld_val  = 3'(lv);
        casc_en = ce;
        for (int i = 0; i < 3; i++) begin
            x.cnt[i]  = 3'(m_cnt[i]);
            x.wrap[i] = m_wrap[i];
            x.tc[i]   = e && !l && (u ? (m_cnt[i] == mod_of(i) - 1) : (m_cnt[i] == 0));
        end
        x.casc = 6'(m_casc);
        q.push_back(x);
        for (int i = 0; i < 3; i++) begin
            model_step(mod_of(i), sat_of(i), r_n, e, u, l, lv, m_cnt[i], nc, nw);
            m_cnt[i]  = nc;
            m_wrap[i] = nw;
        end
        if (!r_n)    m_casc = 0;
        else if (ce) m_casc = (m_casc + 1) % 64;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (dut_cnt[i] !== x.cnt[i]) begin
                    errors++;
                    $display("FAIL count[%0d] t=%0t actual=%0d required=%0d", i, $time, dut_cnt[i], x.cnt[i]);
                end
                tests++;
                if (dut_tc[i] !== x.tc[i]) begin
                    errors++;
                    $display("FAIL tc[%0d] t=%0t actual=%b required=%b", i, $time, dut_tc[i], x.tc[i]);
                end
                tests++;
                if (dut_wrap[i] !== x.wrap[i]) begin
                    errors++;
                    $display("FAIL wrap[%0d] t=%0t actual=%b required=%b", i, $time, dut_wrap[i], x.wrap[i]);
                end
            end
            tests++;
            if ({hi_cnt, lo_cnt} !== x.casc) begin
                errors++;
                $display("FAIL cascade t=%0t actual=%0d required=%0d", $time, {hi_cnt, lo_cnt}, x.casc);
            end
            $display("[TB] t=%0t cnt=%0d/%0d/%0d tc=%b%b%b wrap=%b%b%b casc=%0d",
                     $time, dut_cnt[0], dut_cnt[1], dut_cnt[2],
                     dut_tc[0], dut_tc[1], dut_tc[2],
                     dut_wrap[0], dut_wrap[1], dut_wrap[2], {hi_cnt, lo_cnt});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        up      = 1'b0;
        ld      = 1'b0;
        ld_val  = 3'd0;
        casc_en = 1'b0;
        m_casc  = 0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
        end
        // First reset edge brings every counter to a known state.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Count up 10 edges: wrap at 7->0 (M8), 5->0 (M6), stop at 5 (sat).
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);

        // Count down from reset.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);

        // Loads with enable asserted, including clamped values.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 7, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Load 4, then reset together with load and enable.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);

        // Let the cascade run through a full 0..63 wrap.
        for (int k = 0; k < 70; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);

        // Randomised traffic.
        for (int k = 0; k < 800; k++) begin
            drive(($urandom_range(0, 99) >= 3),
                  ($urandom_range(0, 99) < 75),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 12),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 85));
        end

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
